// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and limits for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;
  localparam int WAIT_MAX = 15;
  localparam int TIMER_W  = 4;
endpackage

// File: rtl/mem_port_arbiter_timer.sv
// access_timer: loadable down-counter that flags the last cycle of a memory access
module access_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);
  logic [TIMER_W-1:0] count;
  // load wins over decrement; the count parks at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory between IF and MEM
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(WAIT_CYCLES - 1);
  arb_state_t state, state_n;
  owner_t owner, last_grant, grant;
  logic we_q, start, finish, zero;
  assign start  = state == ARB_IDLE && (if_req || mem_req);
  assign finish = state == ARB_BUSY && zero;
  access_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (LOAD_VAL),
    .dec      (state == ARB_BUSY),
    .zero     (zero)
  );
  // round-robin pick: on a tie the requester not served last time wins
  always_comb begin
    grant = (if_req && mem_req) ? ((last_grant == OWN_IF) ? OWN_MEM : OWN_IF)
          : (mem_req ? OWN_MEM : OWN_IF);
  end
  // next state: IDLE -> BUSY on grant, BUSY -> RESP on timer expiry, RESP -> IDLE always
  always_comb begin
    state_n = state;
    state_n = start ? ARB_BUSY : finish ? ARB_RESP : (state == ARB_RESP) ? ARB_IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARB_IDLE;
    else state <= state_n;
  // latch the granted request so the memory sees stable inputs for the whole access
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      we_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (start) begin
      owner      <= grant;
      last_grant <= grant;
      we_q       <= grant == OWN_MEM && mem_we;
      sram_addr  <= (grant == OWN_MEM) ? mem_addr : if_addr;
      if (grant == OWN_MEM) sram_wdata <= mem_wdata;
    end
  // capture read data for the owner only; stores leave mem_rdata untouched
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (finish) begin
      if (owner == OWN_IF) if_rdata <= sram_rdata;
      else if (!we_q) mem_rdata <= sram_rdata;
    end
  assign sram_en   = state == ARB_BUSY;
  assign sram_we   = sram_en && we_q;
  assign if_ready  = state == ARB_RESP && owner == OWN_IF;
  assign mem_ready = state == ARB_RESP && owner == OWN_MEM;
  assign if_stall  = if_req && !if_ready;
  assign mem_stall = mem_req && !mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (WAIT 2, 1, 15) checked every cycle against a timeline model
module tb_mem_port_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req[N], if_ready[N], if_stall[N];
  logic        mem_req[N], mem_we[N], mem_ready[N], mem_stall[N];
  logic        sram_en[N], sram_we[N];
  logic [31:0] if_addr[N], if_rdata[N], mem_addr[N], mem_wdata[N], mem_rdata[N];
  logic [31:0] sram_addr[N], sram_wdata[N], sram_rdata[N];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic int wof(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hE3A01005;
    if (a == 32'h8) return 32'h1234_5678;
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(wof(g))) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]),
      .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_ready(mem_ready[g]), .mem_rdata(mem_rdata[g]),
      .mem_stall(mem_stall[g]),
      .sram_en(sram_en[g]), .sram_we(sram_we[g]), .sram_addr(sram_addr[g]),
      .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g])
    );
    assign sram_rdata[g] = memf(sram_addr[g]);
  end

  // Timeline model: a transaction granted at edge s keeps the memory busy after
  // edges s..s+W-1, shows ready after edge s+W, and the port is free again at edge s+W+2.
  bit          m_act[N], m_own[N], m_last[N], m_we[N];
  int          m_start[N];
  logic [31:0] m_addr[N], m_wdata[N], m_ifr[N], m_memr[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_own[i] = 0; m_last[i] = 0; m_we[i] = 0; m_start[i] = 0;
      m_addr[i] = 0; m_wdata[i] = 0; m_ifr[i] = 0; m_memr[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int  w = wof(i);
      bit  free = !m_act[i];
      bit  own;
      if (m_act[i]) begin
        if (cyc - m_start[i] == w) begin
          if (!m_own[i]) m_ifr[i] = memf(m_addr[i]);
          else if (!m_we[i]) m_memr[i] = memf(m_addr[i]);
        end
        if (cyc - m_start[i] == w + 1) m_act[i] = 0;
      end
      if (free && (if_req[i] || mem_req[i])) begin
        own = (if_req[i] && mem_req[i]) ? !m_last[i] : mem_req[i];
        m_act[i] = 1; m_start[i] = cyc; m_own[i] = own; m_last[i] = own;
        m_addr[i] = own ? mem_addr[i] : if_addr[i];
        if (own) m_wdata[i] = mem_wdata[i];
        m_we[i] = own && mem_we[i];
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < N; i++) begin
      int d = cyc - m_start[i];
      bit busy = m_act[i] && d < wof(i);
      bit resp = m_act[i] && d == wof(i);
      bit e_ir = resp && !m_own[i];
      bit e_mr = resp && m_own[i];
      chk($sformatf("if_ready[%0d]", i), if_ready[i], e_ir);
      chk($sformatf("mem_ready[%0d]", i), mem_ready[i], e_mr);
      chk($sformatf("if_stall[%0d]", i), if_stall[i], if_req[i] && !e_ir);
      chk($sformatf("mem_stall[%0d]", i), mem_stall[i], mem_req[i] && !e_mr);
      chk($sformatf("sram_en[%0d]", i), sram_en[i], busy);
      chk($sformatf("sram_we[%0d]", i), sram_we[i], busy && m_we[i]);
      chk($sformatf("sram_addr[%0d]", i), sram_addr[i], m_addr[i]);
      chk($sformatf("sram_wdata[%0d]", i), sram_wdata[i], m_wdata[i]);
      chk($sformatf("if_rdata[%0d]", i), if_rdata[i], m_ifr[i]);
      chk($sformatf("mem_rdata[%0d]", i), mem_rdata[i], m_memr[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_req(input int i, input bit mem, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output int en_n, output int we_n);
    bit done = 0;
    if (mem) begin
      mem_req[i] = 1; mem_we[i] = we; mem_addr[i] = addr; mem_wdata[i] = wd;
    end else begin
      if_req[i] = 1; if_addr[i] = addr;
    end
    lat = 0; en_n = 0; we_n = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      en_n += int'(sram_en[i]);
      we_n += int'(sram_we[i]);
      if (sram_en[i]) chk("busy_addr", sram_addr[i], addr);
      if (sram_we[i]) chk("busy_wdata", sram_wdata[i], wd);
      done = mem ? mem_ready[i] : if_ready[i];
    end
    if (!done) chk("ready_timeout", 32'(lat), 32'(0));
    if (mem) begin mem_req[i] = 0; mem_we[i] = 0; end
    else if_req[i] = 0;
    step();
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (if_req[i] ? (if_ready[i] && $urandom_range(1) == 0) : ($urandom_range(9) < 4)) begin
        if_req[i] = 1; if_addr[i] = $urandom;
      end else if (if_req[i] && if_ready[i]) if_req[i] = 0;
      if (mem_req[i] ? (mem_ready[i] && $urandom_range(1) == 0) : ($urandom_range(9) < 4)) begin
        mem_req[i] = 1; mem_we[i] = 1'($urandom_range(1)); mem_addr[i] = $urandom;
        mem_wdata[i] = $urandom;
      end else if (mem_req[i] && mem_ready[i]) begin
        mem_req[i] = 0; mem_we[i] = 0;
      end
    end
  endtask

  initial begin
    int lat, en_n, we_n, n, guard;
    int seq[6];
    int exp_seq[6] = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < N; i++) begin
      if_req[i] = 0; if_addr[i] = 0; mem_req[i] = 0; mem_we[i] = 0;
      mem_addr[i] = 0; mem_wdata[i] = 0;
    end
    model_reset();
    repeat (2) step();
    rst = 0;
    chk("rst_sram_en", sram_en[0], 0);
    chk("rst_sram_addr", sram_addr[0], 0);
    chk("rst_if_rdata", if_rdata[0], 0);
    step();
    // single IF fetch
    run_req(0, 0, 0, 32'h40, 0, lat, en_n, we_n);
    chk("t1_latency", 32'(lat), 3);
    chk("t1_en_cycles", 32'(en_n), 2);
    chk("t1_if_rdata", if_rdata[0], 32'hE3A01005);
    // single store
    run_req(0, 1, 1, 32'h100, 32'hDEADBEEF, lat, en_n, we_n);
    chk("t2_latency", 32'(lat), 3);
    chk("t2_we_cycles", 32'(we_n), 2);
    chk("t2_mem_rdata", mem_rdata[0], 0);
    // simultaneous requests from reset, held for six transactions
    rst = 1; step(); rst = 0; step();
    for (int k = 0; k < 6; k++) seq[k] = -1;
    if_req[0] = 1; if_addr[0] = 32'h200; mem_req[0] = 1; mem_addr[0] = 32'h300;
    n = 0; guard = 0;
    while (n < 6 && guard < 200) begin
      step();
      guard++;
      if (mem_ready[0]) begin
        if (n == 0) chk("t3_if_stall", if_stall[0], 1);
        seq[n] = 1; n++;
      end else if (if_ready[0]) begin
        seq[n] = 0; n++;
      end
    end
    if_req[0] = 0; mem_req[0] = 0;
    step();
    for (int k = 0; k < 6; k++) chk($sformatf("t4_grant%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    // reset during the second busy cycle of a store
    mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 32'h500; mem_wdata[0] = 32'h0BADF00D;
    step(); step();
    chk("t5_we_before", sram_we[0], 1);
    rst = 1;
    #1;
    chk("t5_sram_en", sram_en[0], 0);
    chk("t5_sram_we", sram_we[0], 0);
    chk("t5_mem_ready", mem_ready[0], 0);
    model_reset();
    mem_req[0] = 0; mem_we[0] = 0;
    step();
    rst = 0;
    step(); step();
    chk("t5_no_ready", mem_ready[0], 0);
    run_req(0, 0, 0, 32'h40, 0, lat, en_n, we_n);
    chk("t5_idle_latency", 32'(lat), 3);
    // shortest and longest memory latency builds
    run_req(1, 0, 0, 32'h8, 0, lat, en_n, we_n);
    chk("t6_w1_latency", 32'(lat), 2);
    chk("t6_w1_rdata", if_rdata[1], 32'h1234_5678);
    run_req(2, 1, 0, 32'h8, 0, lat, en_n, we_n);
    chk("t6_w15_latency", 32'(lat), 16);
    chk("t6_w15_rdata", mem_rdata[2], 32'h1234_5678);
    // random traffic on all three builds
    repeat (1500) begin
      drive_random();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
